tetris_cmd_scheduler: RTL and testbench
=======================================

# tetris_cmd_scheduler

Sequences all commands into the tetris core's `ctrl` port: debounced button levels become one-shot moves with delayed auto-repeat, and a level-scaled gravity timer produces periodic fall commands. All command sources are arbitrated onto a single registered valid/ready command channel. The block sits between the debouncers and the tetris core, in the 50 MHz `clk_50MHz` domain, and replaces the combinational button-to-ctrl mapping.

## Interface
- `GRAVITY_CYCLES`, 25_000_000 — base gravity period in cycles (0.5 s at 50 MHz)
- `DAS_CYCLES`, 12_500_000 — hold time before auto-repeat starts
- `ARR_CYCLES`, 2_500_000 — auto-repeat interval
- `clk`  in  1  system clock (50 MHz)
- `reset`  in  1  synchronous, active-high reset
- `btn`  in  4  debounced button levels: [3] rotate, [2] left, [1] down, [0] right
- `level`  in  4  speed level; gravity period = max(GRAVITY_CYCLES >> level, 1)
- `pause`  in  1  freezes gravity and button event generation
- `cmd`  out  3  command code: 1 gravity, 2 rotate, 3 left, 4 right, 5 soft down; 0 when idle
- `cmd_valid`  out  1  `cmd` holds a command
- `cmd_ready`  in  1  core accepts `cmd`; a transfer happens on a clock edge where `cmd_valid & cmd_ready`

## Operation
- `btn_q` register holds the previous `btn` sample. A rise means `btn & ~btn_q`.
- Each source has one pending flag: gravity, rotate, left, right, down. An event sets its flag. Further events while the flag is set merge into it; they are not counted.
- Repeat FSM for each of left, down and right:
  - IDLE: on rise, raise an event, clear the counter, go to DELAY.
  - DELAY: the counter increments. When it reaches DAS_CYCLES-1, raise an event, clear the counter, go to REPEAT.
  - REPEAT: every ARR_CYCLES cycles, raise an event.
  - Release in any state returns to IDLE next edge. The pending flag is kept.
- Rotate has no repeat: exactly one event per rise.
- Gravity counter (32 bit) increments every non-paused cycle.
  - At count >= period-1, it sets the gravity pending flag and wraps to 0.
  - A level change that leaves count >= new period-1 fires on the next edge.
  - Accepting cmd 5 (soft down) clears the gravity counter on that edge.
- Output register states:
  - EMPTY: `cmd_valid=0`, `cmd=0`.
  - FULL: holds one command. `cmd` is stable while `cmd_valid & ~cmd_ready`.
- Load: when EMPTY, or FULL and transferring this edge, the highest-priority pending flag loads and clears on that edge. Back-to-back transfers are allowed. If nothing is pending, the register goes EMPTY.
- Priority: gravity > rotate > left > right > down. Lower flags wait; they are never dropped.
- An event for a source on the same edge its flag is loaded re-sets the flag. The result is one more command.
- `pause=1` does the following:
  - Freezes the gravity counter and DAS/ARR counters and suppresses new events.
  - Still updates `btn_q`, so rises during pause are lost.
  - Keeps pending flags and continues to drain the output register.

## Timing
- Reset values: `cmd=0`, `cmd_valid=0`, all pending flags 0, `btn_q=0`, all FSMs IDLE, all counters 0.
- Latency: `btn` high before edge k (with `btn_q=0`) sets pending at edge k. `cmd_valid=1` after edge k+1 if the register is EMPTY.
- Gravity timing: with no interference, gravity commands load every `period` cycles.
- Reset mid-operation: state clears at the next edge, including an un-accepted `cmd_valid`.
- `cmd_ready` while `cmd_valid=0` has no effect.

## Test plan
Parameters for all tests: GRAVITY_CYCLES=64, DAS_CYCLES=8, ARR_CYCLES=4, level=0, cmd_ready=1 unless stated.
- Left pressed 1 cycle → exactly one cmd=3. It appears 2 edges after the press. No repeat.
- Right held 30 cycles → cmd=4 at press+2. Then at +8 after the first event. Then every 4 cycles until release. No command after release beyond the one already pending.
- `cmd_ready=0` with rotate and left pressed together → `cmd=2` held stable. When ready rises, 2 then 3 on consecutive edges. A gravity tick arriving during the stall is delivered before 3.
- level=2 → gravity cmd=1 every 16 cycles. Soft down accepted at count 10 → next gravity 16 cycles after that acceptance.
- `pause` asserted for 100 cycles with down held → no commands. A gravity count of 40 at pause resumes from 40.
- Reset while `cmd_valid=1` and 3 flags pending → all outputs 0 next edge. No stale command afterwards.

Source files
------------

// File: rtl/tetris_cmd_scheduler.sv
// Turns debounced button levels and a level-scaled gravity timer into one
// registered valid/ready command stream for the tetris core.
module tetris_cmd_scheduler #(
    parameter int unsigned GRAVITY_CYCLES = 25_000_000,
    parameter int unsigned DAS_CYCLES     = 12_500_000,
    parameter int unsigned ARR_CYCLES     = 2_500_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn,
    input  logic [3:0] level,
    input  logic       pause,
    output logic [2:0] cmd,
    output logic       cmd_valid,
    input  logic       cmd_ready
);

    typedef enum logic [1:0] {
        REP_IDLE   = 2'd0,
        REP_DELAY  = 2'd1,
        REP_REPEAT = 2'd2
    } rep_state_e;

    typedef enum logic [2:0] {
        CMD_NONE    = 3'd0,
        CMD_GRAVITY = 3'd1,
        CMD_ROTATE  = 3'd2,
        CMD_LEFT    = 3'd3,
        CMD_RIGHT   = 3'd4,
        CMD_DOWN    = 3'd5
    } cmd_e;

    // Pending-flag slots, listed in priority order.
    localparam int P_GRAV  = 0;
    localparam int P_ROT   = 1;
    localparam int P_LEFT  = 2;
    localparam int P_RIGHT = 3;
    localparam int P_DOWN  = 4;

    // Repeat FSM slots share the bit position of their button.
    localparam int R_RIGHT = 0;
    localparam int R_DOWN  = 1;
    localparam int R_LEFT  = 2;

    localparam logic [31:0] GRAV_BASE = 32'(GRAVITY_CYCLES);
    localparam logic [31:0] DAS_LAST  = 32'(DAS_CYCLES - 1);
    localparam logic [31:0] ARR_LAST  = 32'(ARR_CYCLES - 1);

    logic [3:0]  btn_q, btn_d;
    logic [3:0]  rise;

    rep_state_e  rep_state_q [3];
    rep_state_e  rep_state_d [3];
    logic [31:0] rep_cnt_q   [3];
    logic [31:0] rep_cnt_d   [3];
    logic [2:0]  rep_event;

    logic [31:0] grav_cnt_q, grav_cnt_d;
    logic [31:0] grav_period;
    logic        grav_event;

    logic [4:0]  pend_q, pend_d;
    logic [4:0]  pend_ev;
    logic [4:0]  pend_clr;

    cmd_e        cmd_q, cmd_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic        xfer;
    logic        load;
    logic        soft_accept;

    assign btn_d       = btn;
    assign rise        = btn & ~btn_q;
    assign xfer        = cmd_valid_q & cmd_ready;
    assign load        = ~cmd_valid_q | cmd_ready;
    assign soft_accept = xfer && (cmd_q == CMD_DOWN);

    // Left, down and right: one event on press, one after DAS, then one per ARR.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
            rep_state_d[i] = rep_state_q[i];
            rep_cnt_d[i]   = rep_cnt_q[i];
            rep_event[i]   = 1'b0;
            if (!btn[i]) begin
                rep_state_d[i] = REP_IDLE;
                rep_cnt_d[i]   = '0;
            end else if (!pause) begin
                case (rep_state_q[i])
                    REP_IDLE: begin
                        if (rise[i]) begin
                            rep_event[i]   = 1'b1;
                            rep_cnt_d[i]   = '0;
                            rep_state_d[i] = REP_DELAY;
                        end
                    end
                    REP_DELAY: begin
                        if (rep_cnt_q[i] == DAS_LAST) begin
                            rep_event[i]   = 1'b1;
                            rep_cnt_d[i]   = '0;
                            rep_state_d[i] = REP_REPEAT;
                        end else begin
                            rep_cnt_d[i] = rep_cnt_q[i] + 32'd1;
                        end
                    end
                    REP_REPEAT: begin
                        if (rep_cnt_q[i] == ARR_LAST) begin
                            rep_event[i] = 1'b1;
                            rep_cnt_d[i] = '0;
                        end else begin
                            rep_cnt_d[i] = rep_cnt_q[i] + 32'd1;
                        end
                    end
                    default: begin
                        rep_state_d[i] = REP_IDLE;
                        rep_cnt_d[i]   = '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        grav_period = GRAV_BASE >> level;
        if (grav_period == 32'd0) begin
            grav_period = 32'd1;
        end
        // Compared with >= so a level change that shortens the period fires at once.
        grav_event = !pause && (grav_cnt_q >= grav_period - 32'd1);
        grav_cnt_d = grav_cnt_q;
        if (!pause) begin
            grav_cnt_d = grav_event ? 32'd0 : grav_cnt_q + 32'd1;
        end
        if (soft_accept) begin
            grav_cnt_d = '0;
        end
    end

    always_comb begin
        pend_ev          = '0;
        pend_ev[P_GRAV]  = grav_event;
        pend_ev[P_ROT]   = rise[3] & ~pause;
        pend_ev[P_LEFT]  = rep_event[R_LEFT];
        pend_ev[P_RIGHT] = rep_event[R_RIGHT];
        pend_ev[P_DOWN]  = rep_event[R_DOWN];
    end

    always_comb begin
        pend_clr    = '0;
        cmd_d       = cmd_q;
        cmd_valid_d = cmd_valid_q;
        if (load) begin
            cmd_valid_d = 1'b1;
            if (pend_q[P_GRAV]) begin
                cmd_d            = CMD_GRAVITY;
                pend_clr[P_GRAV] = 1'b1;
            end else if (pend_q[P_ROT]) begin
                cmd_d           = CMD_ROTATE;
                pend_clr[P_ROT] = 1'b1;
            end else if (pend_q[P_LEFT]) begin
                cmd_d            = CMD_LEFT;
                pend_clr[P_LEFT] = 1'b1;
            end else if (pend_q[P_RIGHT]) begin
                cmd_d             = CMD_RIGHT;
                pend_clr[P_RIGHT] = 1'b1;
            end else if (pend_q[P_DOWN]) begin
                cmd_d            = CMD_DOWN;
                pend_clr[P_DOWN] = 1'b1;
            end else begin
                cmd_valid_d = 1'b0;
                cmd_d       = CMD_NONE;
            end
        end
        // A same-edge event re-arms a flag that is being loaded.
        pend_d = (pend_q & ~pend_clr) | pend_ev;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_q       <= '0;
            grav_cnt_q  <= '0;
            pend_q      <= '0;
            cmd_q       <= CMD_NONE;
            cmd_valid_q <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                rep_state_q[i] <= REP_IDLE;
                rep_cnt_q[i]   <= '0;
            end
        end else begin
            btn_q       <= btn_d;
            grav_cnt_q  <= grav_cnt_d;
            pend_q      <= pend_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            for (int i = 0; i < 3; i++) begin
                rep_state_q[i] <= rep_state_d[i];
                rep_cnt_q[i]   <= rep_cnt_d[i];
            end
        end
    end

    assign cmd       = cmd_q;
    assign cmd_valid = cmd_valid_q;

endmodule

// File: tb/tb_tetris_cmd_scheduler.sv
// Directed bench for tetris_cmd_scheduler with short gravity/DAS/ARR periods;
// edge numbers count posedges after reset is released.
module tb_tetris_cmd_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn;
    logic [3:0] level;
    logic       pause;
    logic [2:0] cmd;
    logic       cmd_valid;
    logic       cmd_ready;

    int tests_run    = 0;
    int tests_failed = 0;

    tetris_cmd_scheduler #(
        .GRAVITY_CYCLES(64),
        .DAS_CYCLES    (8),
        .ARR_CYCLES    (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn      (btn),
        .level    (level),
        .pause    (pause),
        .cmd      (cmd),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish by %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic apply_reset();
        reset     = 1'b1;
        btn       = 4'b0000;
        pause     = 1'b0;
        cmd_ready = 1'b1;
        level     = 4'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        tests_run++;
        if (cmd_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_valid: got %b, expected 0", cmd_valid);
        end
        tests_run++;
        if (cmd !== 3'd0) begin
            tests_failed++;
            $display("FAIL reset_cmd: got %0d, expected 0", cmd);
        end
    endtask

    // Left held for a single edge: one cmd=3 after edge 2, no repeat.
    task automatic test_left_tap();
        logic       exp_v;
        logic [2:0] exp_c;
        apply_reset();
        btn[2] = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            @(posedge clk);
            #1;
            exp_v = (i == 2);
            exp_c = exp_v ? 3'd3 : 3'd0;
            tests_run++;
            if (cmd_valid !== exp_v || cmd !== exp_c) begin
                tests_failed++;
                $display("FAIL left_tap edge %0d: valid=%b cmd=%0d, expected valid=%b cmd=%0d",
                         i, cmd_valid, cmd, exp_v, exp_c);
            end
            if (i == 1) btn[2] = 1'b0;
        end
    endtask

    // Right held over edges 1..30: events at 1, 9, then every 4 up to 29.
    task automatic test_right_hold();
        logic       exp_v;
        logic [2:0] exp_c;
        apply_reset();
        btn[0] = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            exp_v = (i == 2) || (i == 10) || (i == 14) || (i == 18) ||
                    (i == 22) || (i == 26) || (i == 30);
            exp_c = exp_v ? 3'd4 : 3'd0;
            tests_run++;
            if (cmd_valid !== exp_v || cmd !== exp_c) begin
                tests_failed++;
                $display("FAIL right_hold edge %0d: valid=%b cmd=%0d, expected valid=%b cmd=%0d",
                         i, cmd_valid, cmd, exp_v, exp_c);
            end
            if (i == 30) btn[0] = 1'b0;
        end
    endtask

    // Stall with rotate+left pending; gravity fires at edge 64; ready at edge 71.
    task automatic test_back_to_back();
        logic       exp_v;
        logic [2:0] exp_c;
        apply_reset();
        cmd_ready = 1'b0;
        btn       = 4'b1100;
        for (int i = 1; i <= 74; i++) begin
            @(posedge clk);
            #1;
            if (i >= 2 && i <= 70) begin
                exp_v = 1'b1; exp_c = 3'd2;
            end else if (i == 71) begin
                exp_v = 1'b1; exp_c = 3'd1;
            end else if (i == 72) begin
                exp_v = 1'b1; exp_c = 3'd3;
            end else begin
                exp_v = 1'b0; exp_c = 3'd0;
            end
            tests_run++;
            if (cmd_valid !== exp_v || cmd !== exp_c) begin
                tests_failed++;
                $display("FAIL stall_drain edge %0d: valid=%b cmd=%0d, expected valid=%b cmd=%0d",
                         i, cmd_valid, cmd, exp_v, exp_c);
            end
            if (i == 1)  btn       = 4'b0000;
            if (i == 70) cmd_ready = 1'b1;
        end
    endtask

    // level=2 (period 16): gravity at 17; soft down accepted at edge 27 (count 10)
    // restarts the period, so gravity follows at 44 and 60 instead of 33.
    task automatic test_gravity_soft_down();
        logic       exp_v;
        logic [2:0] exp_c;
        apply_reset();
        level = 4'd2;
        for (int i = 1; i <= 62; i++) begin
            @(posedge clk);
            #1;
            if (i == 17 || i == 44 || i == 60) begin
                exp_v = 1'b1; exp_c = 3'd1;
            end else if (i == 26) begin
                exp_v = 1'b1; exp_c = 3'd5;
            end else begin
                exp_v = 1'b0; exp_c = 3'd0;
            end
            tests_run++;
            if (cmd_valid !== exp_v || cmd !== exp_c) begin
                tests_failed++;
                $display("FAIL gravity_soft edge %0d: valid=%b cmd=%0d, expected valid=%b cmd=%0d",
                         i, cmd_valid, cmd, exp_v, exp_c);
            end
            if (i == 24) btn[1] = 1'b1;
            if (i == 25) btn[1] = 1'b0;
        end
    endtask

    // Pause over edges 41..140 with down held: nothing issues, gravity resumes from 40.
    task automatic test_pause();
        logic       exp_v;
        logic [2:0] exp_c;
        apply_reset();
        for (int i = 1; i <= 170; i++) begin
            @(posedge clk);
            #1;
            exp_v = (i == 165);
            exp_c = exp_v ? 3'd1 : 3'd0;
            tests_run++;
            if (cmd_valid !== exp_v || cmd !== exp_c) begin
                tests_failed++;
                $display("FAIL pause edge %0d: valid=%b cmd=%0d, expected valid=%b cmd=%0d",
                         i, cmd_valid, cmd, exp_v, exp_c);
            end
            if (i == 40) begin
                pause  = 1'b1;
                btn[1] = 1'b1;
            end
            if (i == 140) begin
                pause = 1'b0;
                btn   = 4'b0000;
            end
        end
    endtask

    // Reset while cmd=2 is stalled with left/right/down still pending.
    task automatic test_reset_mid_op();
        apply_reset();
        cmd_ready = 1'b0;
        btn       = 4'b1111;
        @(posedge clk);
        #1 btn = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (cmd_valid !== 1'b1 || cmd !== 3'd2) begin
            tests_failed++;
            $display("FAIL mid_op_before: valid=%b cmd=%0d, expected valid=1 cmd=2", cmd_valid, cmd);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (cmd_valid !== 1'b0 || cmd !== 3'd0) begin
            tests_failed++;
            $display("FAIL mid_op_reset: valid=%b cmd=%0d, expected valid=0 cmd=0", cmd_valid, cmd);
        end
        reset     = 1'b0;
        cmd_ready = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            tests_run++;
            if (cmd_valid !== 1'b0 || cmd !== 3'd0) begin
                tests_failed++;
                $display("FAIL mid_op_after edge %0d: valid=%b cmd=%0d, expected valid=0 cmd=0",
                         i, cmd_valid, cmd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_left_tap();
        test_right_hold();
        test_back_to_back();
        test_gravity_soft_down();
        test_pause();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
